// File: rtl/cla_bist_ctrl.sv
`timescale 1ns/1ps
// Built-in self-test sequencer for a WIDTH-bit CLA adder/subtractor: drives 9 corner
// vectors then N_RANDOM LFSR vectors, checks each against a behavioural model.
module cla_bist_ctrl #(
    parameter int          WIDTH         = 15,
    parameter int          N_RANDOM      = 64,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2345
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] A_o,
    output logic [WIDTH-1:0] B_o,
    output logic             mode_o,
    input  logic [WIDTH-1:0] S_i,
    input  logic             Cout_i,
    input  logic             Ovf_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       err_count,
    output logic [15:0]      first_fail_idx,
    output logic [2:0]       o_dbg_state
);
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] LAST_IDX    = 16'(9 + N_RANDOM - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [31:0] SEED_EFF    = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_mode;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [7:0]         r_err;
    logic [15:0]        r_ffi;
    logic [15:0]        r_idx;
    logic [15:0]        r_settle;
    logic [31:0]        r_lfsr;

    logic [2*WIDTH:0]   w_vec;
    logic [WIDTH-1:0]   w_bx;
    logic [WIDTH:0]     w_sum;
    logic               w_ovf;
    logic               w_mismatch;
    logic [31:0]        w_lfsr_next;

    // Packed as {mode, B, A}.
    function automatic logic [2*WIDTH:0] directed_vec(input logic [3:0] i);
        logic [2*WIDTH:0] v;
        case (i)
            4'd1:    v = {1'b0, WIDTH'(16'h0007), WIDTH'(16'h0009)};
            4'd2:    v = {1'b0, WIDTH'(16'h0001), WIDTH'(16'h3FFF)};
            4'd3:    v = {1'b0, WIDTH'(16'h0004), WIDTH'(16'h7FFE)};
            4'd4:    v = {1'b0, WIDTH'(16'h4000), WIDTH'(16'h6000)};
            4'd5:    v = {1'b1, WIDTH'(16'h0046), WIDTH'(16'h001E)};
            4'd6:    v = {1'b1, WIDTH'(16'h6000), WIDTH'(16'h2000)};
            4'd7:    v = {1'b1, WIDTH'(16'h0007), WIDTH'(16'h000A)};
            4'd8:    v = {1'b1, WIDTH'(16'h0003), WIDTH'(16'h4002)};
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        w_vec       = (r_idx < 16'd9) ? directed_vec(r_idx[3:0])
                    : {r_lfsr[31], r_lfsr[2*WIDTH-1:WIDTH], r_lfsr[WIDTH-1:0]};
        w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
        // Subtract is A + ~B + 1, so Cout=1 means no borrow.
        w_bx        = r_mode ? ~r_b : r_b;
        w_sum       = {1'b0, r_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, r_mode};
        w_ovf       = (r_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        w_mismatch  = (S_i != w_sum[WIDTH-1:0]) || (Cout_i != w_sum[WIDTH]) || (Ovf_i != w_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= 8'd0;
            r_ffi    <= 16'hFFFF;
            r_idx    <= 16'd0;
            r_settle <= 16'd0;
            r_lfsr   <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_err   <= 8'd0;
                        r_ffi   <= 16'hFFFF;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_lfsr  <= SEED_EFF;
                        r_idx   <= 16'd0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DRIVE;
                    end else if (r_state == ST_DONE) begin
                        r_done <= 1'b1;
                        r_pass <= (r_err == 8'd0);
                    end
                end
                ST_DRIVE: begin
                    {r_mode, r_b, r_a} <= w_vec;
                    r_settle           <= 16'd0;
                    r_state            <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle + 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err != 8'hFF) begin
                            r_err <= r_err + 8'd1;
                        end
                        // err_count only leaves zero on the first mismatch of a run.
                        if (r_err == 8'd0) begin
                            r_ffi <= r_idx;
                        end
                    end
                    if (r_idx >= 16'd9) begin
                        r_lfsr <= w_lfsr_next;
                    end
                    r_idx <= r_idx + 16'd1;
                    if (r_idx == LAST_IDX) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_DRIVE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign A_o            = r_a;
    assign B_o            = r_b;
    assign mode_o         = r_mode;
    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_idx = r_ffi;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_cla_bist_ctrl.sv
`timescale 1ns/1ps
// Directed bench for cla_bist_ctrl: an arithmetic adder stand-in with selectable faults,
// a vector scoreboard on every CHECK cycle, and timing/result checks per run.
module tb_cla_bist_ctrl;
  localparam int W  = 15;
  localparam int VW = 2 * W + 1;
  localparam int NV = 9 + 64;
  localparam int NV_SAT = 9 + 300;
  localparam logic [31:0] SEED = 32'hACE1_2345;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_SETTLE = 3'd2, ST_CHECK = 3'd3;

  logic clk, rst_n, start, start_sat;
  logic [W-1:0] a_o, b_o, s_i, a_s, b_s, s_s;
  logic mode_o, cout_i, ovf_i, mode_s, cout_s, ovf_s;
  logic busy, done, pass, busy_s, done_s, pass_s;
  logic [7:0] err_count, err_s;
  logic [15:0] ffi, ffi_s;
  logic [2:0] dbg, dbg_s;
  int fault_sel;

  int n_cmp, n_fail;
  int exp_err, exp_ffi, edges;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] dir_tab [9];

  cla_bist_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .A_o(a_o), .B_o(b_o), .mode_o(mode_o),
    .S_i(s_i), .Cout_i(cout_i), .Ovf_i(ovf_i),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(ffi), .o_dbg_state(dbg)
  );

  cla_bist_ctrl #(.N_RANDOM(300)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start_sat),
    .A_o(a_s), .B_o(b_s), .mode_o(mode_s),
    .S_i(s_s), .Cout_i(cout_s), .Ovf_i(ovf_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_fail_idx(ffi_s), .o_dbg_state(dbg_s)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Adder stand-in in signed/unsigned integer arithmetic. f: 1=S[0] stuck 0, 2=Ovf stuck 0, 3=Ovf inverted.
  function automatic logic [W+1:0] adder(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic m, input int f);
    int sa, sb, r;
    logic [W-1:0] s;
    logic c, o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = m ? sa - sb : sa + sb;
    o = (r > 16383) || (r < -16384);
    s = m ? a - b : a + b;
    c = m ? (a >= b) : ((int'(a) + int'(b)) > 32767);
    if (f == 1) s[0] = 1'b0;
    if (f == 2) o = 1'b0;
    if (f == 3) o = ~o;
    return {o, c, s};
  endfunction

  always_comb {ovf_i, cout_i, s_i} = adder(a_o, b_o, mode_o, fault_sel);
  always_comb {ovf_s, cout_s, s_s} = adder(a_s, b_s, mode_s, 3);

  function automatic logic [31:0] lfsr_next(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every CHECK cycle must present the next expected {mode,B,A}
  always @(negedge clk) begin
    logic [VW-1:0] v;
    if (rst_n && dbg == ST_CHECK) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL vec_extra observed=%0h expected=none", {mode_o, b_o, a_o});
      end else begin
        v = exp_q.pop_front();
        assert ({mode_o, b_o, a_o} === v) else begin
          n_fail++;
          $error("FAIL vec observed=%0h expected=%0h", {mode_o, b_o, a_o}, v);
        end
      end
    end
  end

  task automatic build_exp(input int f);
    logic [31:0] l;
    logic [VW-1:0] v;
    l = SEED;
    exp_err = 0;
    exp_ffi = 32'hFFFF;
    for (int i = 0; i < NV; i++) begin
      v = (i < 9) ? dir_tab[i] : {l[31], l[29:15], l[14:0]};
      if (i >= 9) l = lfsr_next(l);
      exp_q.push_back(v);
      if (adder(v[W-1:0], v[2*W-1:W], v[2*W], f) != adder(v[W-1:0], v[2*W-1:W], v[2*W], 0)) begin
        if (exp_err == 0) exp_ffi = i;
        if (exp_err < 255) exp_err++;
      end
    end
  endtask

  // driver: pulse start, check the accepted-start state
  task automatic pulse_start(input int f);
    build_exp(f);
    fault_sel = f;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("err_cleared", err_count, 0);
    chk("ffi_cleared", ffi, 32'hFFFF);
  endtask

  task automatic wait_done(input int repulse_at);
    edges = 0;
    while (edges < 400 && !done) begin
      @(posedge clk);
      edges++;
      #1 start = (edges == repulse_at);
    end
    start = 1'b0;
    chk("done_edge", edges, NV * 3 + 1);
    chk("busy_at_done", busy, 0);
    chk("err_count", err_count, exp_err);
    chk("first_fail_idx", ffi, exp_ffi);
    chk("pass", pass, (exp_err == 0) ? 1 : 0);
    chk("all_vectors_seen", exp_q.size(), 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a"}, a_o, 0);
    chk({tag, "_b"}, b_o, 0);
    chk({tag, "_mode"}, mode_o, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_ffi"}, ffi, 32'hFFFF);
    chk({tag, "_state"}, dbg, ST_IDLE);
  endtask

  initial begin
    dir_tab = '{{1'b0, 15'h0000, 15'h0000}, {1'b0, 15'h0007, 15'h0009},
                {1'b0, 15'h0001, 15'h3FFF}, {1'b0, 15'h0004, 15'h7FFE},
                {1'b0, 15'h4000, 15'h6000}, {1'b1, 15'h0046, 15'h001E},
                {1'b1, 15'h6000, 15'h2000}, {1'b1, 15'h0007, 15'h000A},
                {1'b1, 15'h0003, 15'h4002}};
    n_cmp = 0;
    n_fail = 0;
    fault_sel = 0;
    rst_n = 1'b0;
    start = 1'b0;
    start_sat = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle_no_start", dbg, ST_IDLE);

    // golden run, start re-pulsed mid-run must be ignored
    pulse_start(0);
    wait_done(50);

    // start from DONE with S[0] stuck at 0: first failure is 000A-0007
    pulse_start(1);
    wait_done(-1);
    chk("stuck_s0_ffi_is_7", ffi, 7);

    // Ovf stuck at 0: first failure is 3FFF+0001
    pulse_start(2);
    wait_done(-1);
    chk("ovf0_ffi_is_2", ffi, 2);

    // async reset in the middle of a SETTLE cycle after errors accumulated
    pulse_start(1);
    edges = 0;
    while (edges < 100 && !(edges >= 40 && dbg == ST_SETTLE)) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk("reached_settle", dbg, ST_SETTLE);
    chk("errs_before_reset", (err_count != 0) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrun_reset");
    exp_q.delete();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // identical vector sequence after reset
    pulse_start(0);
    wait_done(-1);

    // Ovf inverted over 309 vectors: err_count saturates
    @(negedge clk) start_sat = 1'b1;
    @(posedge clk);
    #1 start_sat = 1'b0;
    edges = 0;
    while (edges < 2000 && !done_s) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk("sat_done_edge", edges, NV_SAT * 3 + 1);
    chk("sat_err_255", err_s, 255);
    chk("sat_ffi_0", ffi_s, 0);
    chk("sat_pass", pass_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
